zxuno_cfg_sequencer: RTL

ZXUNO_CFG_SEQUENCER -- requirements
Module: zxuno_cfg_sequencer

---
 rtl/zxuno_cfg_sequencer_pkg.sv | 32 +++
 rtl/zxuno_cfg_sequencer_rom.sv | 41 ++++
 rtl/zxuno_cfg_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/zxuno_cfg_sequencer_pkg.sv
// Shared zxuno register definitions: sequencer state encoding, option register
// addresses and the configuration table entry layout.
package zxuno_cfg_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_WRITE,
    ST_READ,
    ST_CHECK,
    ST_DONE
  } seq_state_e;

  localparam logic [7:0] DEVOPTIONS = 8'h0E;
  localparam logic [7:0] DEVOPTS2   = 8'h0F;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       valid;
  } cfg_entry_t;

  // A read-back is bad when the register block did not drive the bus or
  // returned something other than what was written.
  function automatic logic readback_bad(input logic       oe_n,
                                        input logic [7:0] got,
                                        input logic [7:0] exp);
    return oe_n || (got != exp);
  endfunction

endpackage

// File: rtl/zxuno_cfg_sequencer_rom.sv
// Default boot configuration table; synchronous read, entry appears one clock
// after idx changes. Contents: DEVOPTIONS=00, DEVOPTS2=00, then end marker.
module cfg_table_rom
  import zxuno_cfg_sequencer_pkg::*;
#(
  parameter  int NUM_ENTRIES = 8,
  localparam int IW          = $clog2(NUM_ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] idx,
  output logic [7:0]    addr,
  output logic [7:0]    data,
  output logic          valid
);

  cfg_entry_t rom_d;
  cfg_entry_t rom_q;

  always_comb begin
    rom_d = '0;
    if (idx == IW'(0)) begin
      rom_d = '{addr: DEVOPTIONS, data: 8'h00, valid: 1'b1};
    end else if (idx == IW'(1)) begin
      rom_d = '{addr: DEVOPTS2, data: 8'h00, valid: 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_q <= '0;
    end else begin
      rom_q <= rom_d;
    end
  end

  assign addr  = rom_q.addr;
  assign data  = rom_q.data;
  assign valid = rom_q.valid;

endmodule

// File: rtl/zxuno_cfg_sequencer.sv
// Boot-time option register sequencer: walks a config table, writes each entry and
// optionally reads it back; 5 clk/entry (4 without verify), stalls on any CPU cycle.
module zxuno_cfg_sequencer
  import zxuno_cfg_sequencer_pkg::*;
#(
  parameter  int NUM_ENTRIES = 8,
  parameter  bit AUTOSTART   = 1'b1,
  parameter  bit VERIFY      = 1'b1,
  localparam int IW          = $clog2(NUM_ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    cpu_addr,
  input  logic [7:0]    cpu_din,
  input  logic          cpu_regwr,
  input  logic          cpu_regrd,
  output logic [7:0]    zxuno_addr,
  output logic [7:0]    zxuno_din,
  output logic          zxuno_regwr,
  output logic          zxuno_regrd,
  input  logic [7:0]    rd_dout,
  input  logic          rd_oe_n,
  output logic [IW-1:0] tbl_idx,
  input  logic [7:0]    tbl_addr,
  input  logic [7:0]    tbl_data,
  input  logic          tbl_valid,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [IW-1:0] err_idx
);

  seq_state_e    state_q, state_d;
  logic          auto_q, auto_d;
  logic [IW-1:0] tbl_idx_q, tbl_idx_d;
  cfg_entry_t    ent_q, ent_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_oe_n_q, rd_oe_n_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [IW-1:0] err_idx_q, err_idx_d;
  logic          cpu_cycle;

  assign cpu_cycle = cpu_regwr | cpu_regrd;

  // The CPU always wins the bus; the whole sequencer freezes for that cycle so
  // an owed strobe is simply issued on the next free cycle.
  always_comb begin
    state_d   = state_q;
    auto_d    = auto_q;
    tbl_idx_d = tbl_idx_q;
    ent_d     = ent_q;
    rd_data_d = rd_data_q;
    rd_oe_n_d = rd_oe_n_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    if (!cpu_cycle) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start || auto_q) begin
            state_d   = ST_FETCH;
            auto_d    = 1'b0;
            tbl_idx_d = '0;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            err_d     = 1'b0;
            err_idx_d = '0;
          end
        end
        ST_FETCH: state_d = ST_WAIT;
        ST_WAIT: begin
          ent_d   = '{addr: tbl_addr, data: tbl_data, valid: tbl_valid};
          state_d = tbl_valid ? ST_WRITE : ST_DONE;
        end
        ST_WRITE: state_d = VERIFY ? ST_READ : ST_CHECK;
        ST_READ: begin
          rd_data_d = rd_dout;
          rd_oe_n_d = rd_oe_n;
          state_d   = ST_CHECK;
        end
        ST_CHECK: begin
          if (VERIFY && !err_q && readback_bad(rd_oe_n_q, rd_data_q, ent_q.data)) begin
            err_d     = 1'b1;
            err_idx_d = tbl_idx_q;
          end
          if (tbl_idx_q == IW'(NUM_ENTRIES - 1)) begin
            state_d = ST_DONE;
          end else begin
            tbl_idx_d = tbl_idx_q + IW'(1);
            state_d   = ST_FETCH;
          end
        end
        ST_DONE: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      auto_q    <= AUTOSTART;
      tbl_idx_q <= '0;
      ent_q     <= '0;
      rd_data_q <= '0;
      rd_oe_n_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      auto_q    <= auto_d;
      tbl_idx_q <= tbl_idx_d;
      ent_q     <= ent_d;
      rd_data_q <= rd_data_d;
      rd_oe_n_q <= rd_oe_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  // Bus mux is combinational so a reset drops an in-flight strobe immediately.
  always_comb begin
    zxuno_addr  = cpu_addr;
    zxuno_din   = cpu_din;
    zxuno_regwr = cpu_regwr;
    zxuno_regrd = cpu_regrd;
    if (!cpu_cycle) begin
      if (state_q == ST_WRITE) begin
        zxuno_addr  = ent_q.addr;
        zxuno_din   = ent_q.data;
        zxuno_regwr = 1'b1;
      end else if (state_q == ST_READ) begin
        zxuno_addr  = ent_q.addr;
        zxuno_din   = ent_q.data;
        zxuno_regrd = 1'b1;
      end
    end
  end

  assign tbl_idx = tbl_idx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign err_idx = err_idx_q;

endmodule
